// File: rtl/fetch_queue.sv
// Prefetch queue: sequential imem reads into a DEPTH-entry {pc,insn} FIFO for decode; FETCH_QUEUE_STATS_EN adds stat counters.
// Latency: imem_rvalid_i -> dec_valid_o 1 cycle; backpressure: issue stalls once count+outstanding reaches DEPTH.
module fetch_queue #(
    parameter int                AWIDTH         = 32,
    parameter int                DWIDTH         = 32,
    parameter int                DEPTH          = 4,
    parameter int                MAX_INFLIGHT   = 2,
    parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = 32'h0100_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_i,
    input  logic [AWIDTH-1:0]        redirect_pc_i,
    output logic                     imem_req_o,
    output logic [AWIDTH-1:0]        imem_addr_o,
    input  logic                     imem_rvalid_i,
    input  logic [DWIDTH-1:0]        imem_rdata_i,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [AWIDTH-1:0]        dec_pc_o,
    output logic [DWIDTH-1:0]        dec_insn_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]              stat_stall_cycles_o,
    output logic [31:0]              stat_flushes_o,
    output logic [31:0]              stat_discards_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_INFLIGHT + 1);
    localparam int TW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int SW = CW + OW;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [OW-1:0] MAXI_S  = OW'(MAX_INFLIGHT);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_INFLIGHT - 1);

    logic [AWIDTH-1:0] fifo_pc_q   [DEPTH];
    logic [DWIDTH-1:0] fifo_insn_q [DEPTH];
    logic [AWIDTH-1:0] tag_q       [MAX_INFLIGHT];

    logic [AWIDTH-1:0] next_pc_q,  next_pc_d;
    logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [OW-1:0]     out_q,      out_d;
    logic [OW-1:0]     discard_q,  discard_d;
    logic [TW-1:0]     tag_wr_q,   tag_wr_d;
    logic [TW-1:0]     tag_rd_q,   tag_rd_d;
    logic [AWIDTH-1:0] last_pc_q;
    logic [DWIDTH-1:0] last_insn_q;

    logic empty, room, issue, resp, drop, push, pop;

    assign empty = (count_q == '0);
    assign room  = ({{OW{1'b0}}, count_q} + {{CW{1'b0}}, out_q}) < DEPTH_S;
    assign issue = !rst && !redirect_i && room && (out_q < MAXI_S);
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp  = imem_rvalid_i && (out_q != '0);
    assign drop  = resp && (redirect_i || (discard_q != '0));
    assign push  = resp && !drop;
    assign pop   = dec_valid_o && dec_ready_i;

    assign imem_req_o  = issue;
    assign imem_addr_o = next_pc_q;
    assign dec_valid_o = !rst && !empty && !redirect_i;
    assign occupancy_o = rst ? '0 : count_q;
    assign dec_pc_o    = rst ? '0 : (empty ? last_pc_q   : fifo_pc_q[rd_ptr_q]);
    assign dec_insn_o  = rst ? '0 : (empty ? last_insn_q : fifo_insn_q[rd_ptr_q]);

    always_comb begin
        next_pc_d = next_pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        discard_d = discard_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        out_d     = out_q + OW'(issue) - OW'(resp);
        if (issue) begin
            next_pc_d = next_pc_q + AWIDTH'(4);
            tag_wr_d  = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
        end
        if (resp) begin
            tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);
        end
        if (redirect_i) begin
            // Every request still in flight after this cycle belongs to the old stream.
            next_pc_d = redirect_pc_i & ~AWIDTH'(3);
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            discard_d = out_q - OW'(resp);
        end else begin
            if (drop) discard_d = discard_q - OW'(1);
            if (push) wr_ptr_d  = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d  = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_pc_q   <= IMEM_BASE_ADDR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            discard_q   <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            last_pc_q   <= '0;
            last_insn_q <= '0;
        end else begin
            next_pc_q <= next_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_q     <= out_d;
            discard_q <= discard_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            if (pop) begin
                last_pc_q   <= fifo_pc_q[rd_ptr_q];
                last_insn_q <= fifo_insn_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && issue) begin
            tag_q[tag_wr_q] <= next_pc_q;
        end
        if (!rst && push) begin
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            fifo_insn_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_q, flush_q, disc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            disc_q  <= '0;
        end else begin
            if (dec_ready_i && !dec_valid_o && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (redirect_i && (flush_q != '1))                  flush_q <= flush_q + 32'd1;
            if (drop && (disc_q != '1))                         disc_q  <= disc_q + 32'd1;
        end
    end

    assign stat_stall_cycles_o = stall_q;
    assign stat_flushes_o      = flush_q;
    assign stat_discards_o     = disc_q;
`endif

`ifndef SYNTHESIS
    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid_i && (out_q == '0)));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order variable-latency memory model plus a PC/insn scoreboard.
module tb_fetch_queue;
    localparam int          MAXI = 2;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_insn_o;
    logic [2:0]  occupancy_o;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_stall_cycles_o, stat_flushes_o, stat_discards_o;
`endif

    fetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_insn_o    (dec_insn_o),
        .occupancy_o   (occupancy_o)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_stall_cycles_o (stat_stall_cycles_o),
        .stat_flushes_o      (stat_flushes_o),
        .stat_discards_o     (stat_discards_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          pops     = 0;
    int          tb_out   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'hdead_beef;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    // Memory model and scoreboard: sample mid-cycle, drive responses just after the edge.
    initial begin
        logic [31:0] e;
        exp_next = BASE;
        forever begin
            @(negedge clk);
            tb_out = mq.size() + (imem_rvalid_i ? 1 : 0);
            if (rst) begin
                mq.delete();
                exp_q.delete();
                exp_next = BASE;
            end else begin
                n_checks++;
                if (tb_out > MAXI) begin
                    n_fail++;
                    $display("FAIL outstanding: got %0d, limit %0d", tb_out, MAXI);
                end
                if (redirect_i) begin
                    exp_q.delete();
                    exp_next = redirect_pc_i & ~32'h3;
                    n_checks++;
                    if (imem_req_o !== 1'b0) begin
                        n_fail++;
                        $display("FAIL redirect_req: got %b, want 0", imem_req_o);
                    end
                end else begin
                    if (imem_req_o) begin
                        n_checks++;
                        if (imem_addr_o !== exp_next) begin
                            n_fail++;
                            $display("FAIL req_addr: got %h, want %h", imem_addr_o, exp_next);
                        end
                        n_checks++;
                        if (tb_out >= MAXI) begin
                            n_fail++;
                            $display("FAIL issue_limit: issued with %0d outstanding", tb_out);
                        end
                        exp_q.push_back(exp_next);
                        exp_next = exp_next + 32'd4;
                        mq.push_back('{imem_addr_o, cyc + lat});
                    end
                    if (dec_valid_o && dec_ready_i) begin
                        pops++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected: got pc %h, want nothing", dec_pc_o);
                        end else begin
                            e = exp_q.pop_front();
                            if (dec_pc_o !== e || dec_insn_o !== insn_of(e)) begin
                                n_fail++;
                                $display("FAIL sb_pop: got pc %h insn %h, want pc %h insn %h",
                                         dec_pc_o, dec_insn_o, e, insn_of(e));
                            end
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = insn_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'h0;
            end
        end
    end

    task automatic test_reset();
        repeat (3) tick();
        look();
        n_checks++;
        if (imem_req_o !== 1'b0 || dec_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req %b valid %b, want 0 0", imem_req_o, dec_valid_o);
        end
        n_checks++;
        if (occupancy_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_occ: got %0d, want 0", occupancy_o);
        end
        n_checks++;
        if (dec_pc_o !== 32'h0 || dec_insn_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h, want 0 0", dec_pc_o, dec_insn_o);
        end
    endtask

    task automatic test_stream();
        int p0;
        tick();
        rst = 1'b0;
        dec_ready_i = 1'b1;
        look();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== BASE) begin
            n_fail++;
            $display("FAIL stream_c0: got req %b addr %h, want 1 %h", imem_req_o, imem_addr_o, BASE);
        end
        tick();
        look();
        n_checks++;
        if (imem_rvalid_i !== 1'b1 || dec_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_c1: got rvalid %b valid %b, want 1 0", imem_rvalid_i, dec_valid_o);
        end
        tick();
        look();
        n_checks++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== BASE) begin
            n_fail++;
            $display("FAIL stream_c2: got valid %b pc %h, want 1 %h", dec_valid_o, dec_pc_o, BASE);
        end
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            tick();
            look();
            n_checks++;
            if (dec_valid_o !== 1'b1 || occupancy_o > 3'd1) begin
                n_fail++;
                $display("FAIL stream_rate: got valid %b occ %0d, want 1 <=1", dec_valid_o, occupancy_o);
            end
        end
        n_checks++;
        if (pops - p0 !== 20) begin
            n_fail++;
            $display("FAIL stream_count: got %0d pops, want 20", pops - p0);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        tick();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            look();
        end
        n_checks++;
        if (occupancy_o !== 3'd4 || imem_req_o !== 1'b0 || dec_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: got occ %0d req %b valid %b, want 4 0 1",
                     occupancy_o, imem_req_o, dec_valid_o);
        end
        p0 = pops;
        tick();
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            look();
            n_checks++;
            if (dec_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_drain: got valid %b at pop %0d, want 1", dec_valid_o, i);
            end
            tick();
        end
        n_checks++;
        if (pops - p0 !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pops, want 4", pops - p0);
        end
    endtask

    task automatic test_latency3();
        int p0;
        lat = 3;
        p0 = pops;
        for (int i = 0; i < 40; i++) begin
            tick();
            look();
        end
        n_checks++;
        if (pops - p0 < 15) begin
            n_fail++;
            $display("FAIL lat3_rate: got %0d pops in 40 cycles, want >=15", pops - p0);
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        bit seen = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            look();
            if (tb_out == 2 && !imem_rvalid_i && !imem_req_o) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL redir_setup: got no cycle with 2 outstanding, want one within 20");
        end
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0100_0102;
        look();
        n_checks++;
        if (tb_out !== 2 || dec_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle: got outstanding %0d valid %b, want 2 0", tb_out, dec_valid_o);
        end
        tick();
        redirect_i = 1'b0;
        look();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0100_0100) begin
            n_fail++;
            $display("FAIL redir_req: got req %b addr %h, want 1 01000100", imem_req_o, imem_addr_o);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            look();
            if (dec_valid_o) seen = 1;
        end
        n_checks++;
        if (!seen || dec_pc_o !== 32'h0100_0100) begin
            n_fail++;
            $display("FAIL redir_first: got valid %b pc %h, want 1 01000100", seen, dec_pc_o);
        end
    endtask

    task automatic test_redirect_collide();
        lat = 1;
        repeat (8) tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0100_0200;
        look();
        n_checks++;
        if (imem_rvalid_i !== 1'b1 || dec_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_cycle: got rvalid %b valid %b, want 1 0", imem_rvalid_i, dec_valid_o);
        end
        tick();
        redirect_i = 1'b0;
        look();
        n_checks++;
        if (occupancy_o !== 3'd0 || dec_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_after: got occ %0d valid %b, want 0 0", occupancy_o, dec_valid_o);
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        lat = 3;
        dec_ready_i = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            look();
            if (occupancy_o >= 3'd2 && tb_out >= 1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rmid_setup: got occ %0d outstanding %0d, want >=2 >=1", occupancy_o, tb_out);
        end
        tick();
        rst = 1'b1;
        look();
        n_checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 3'd0 || imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_during: got valid %b occ %0d req %b, want 0 0 0",
                     dec_valid_o, occupancy_o, imem_req_o);
        end
        tick();
        rst = 1'b0;
        lat = 1;
        dec_ready_i = 1'b1;
        look();
        n_checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
            n_fail++;
            $display("FAIL rmid_after: got valid %b occ %0d, want 0 0", dec_valid_o, occupancy_o);
        end
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== BASE) begin
            n_fail++;
            $display("FAIL rmid_restart: got req %b addr %h, want 1 %h", imem_req_o, imem_addr_o, BASE);
        end
        repeat (10) tick();
    endtask

    initial begin
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        dec_ready_i   = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_latency3();
        test_redirect();
        test_redirect_collide();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
